pipe_scoreboard: RTL and testbench

Parametrised register scoreboard and bypass unit for the pipelined core. It replaces the fixed two-operand, single-producer hazard check with per-register outstanding-write counters, so multi-cycle producers (loads, mul/div) and several write-back ports can be in flight at once. It sits beside decode: decode presents an instruction for issue, the scoreboard grants or stalls it, and write-back ports retire pending writes and supply same-cycle bypass data.

---
 rtl/pipe_scoreboard_if.sv | 37 +++
 rtl/pipe_scoreboard.sv | 119 +++++++++++
 tb/tb_pipe_scoreboard.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_scoreboard_if.sv
// Issue / write-back / bypass bundle between decode, the write-back ports
// and pipe_scoreboard.
//   master : decode + write-back side (drives issue_*, flush, wb_*)
//   slave  : scoreboard (drives issue_ready, fwd_valid, fwd_data, busy)
interface pipe_scoreboard_if #(
  parameter int unsigned NREG   = 32,
  parameter int unsigned AW     = $clog2(NREG),
  parameter int unsigned NSRC   = 2,
  parameter int unsigned NWB    = 2,
  parameter int unsigned DATA_W = 64
) ();
  logic                   issue_valid;
  logic [NSRC*AW-1:0]     issue_rs;
  logic [NSRC-1:0]        issue_rs_used;
  logic                   issue_wen;
  logic [AW-1:0]          issue_rd;
  logic                   issue_ready;
  logic                   flush;
  logic [NWB-1:0]         wb_valid;
  logic [NWB*AW-1:0]      wb_dst;
  logic [NWB*DATA_W-1:0]  wb_data;
  logic [NSRC-1:0]        fwd_valid;
  logic [NSRC*DATA_W-1:0] fwd_data;
  logic [NREG-1:0]        busy;

  modport master (
    output issue_valid, issue_rs, issue_rs_used, issue_wen, issue_rd,
           flush, wb_valid, wb_dst, wb_data,
    input  issue_ready, fwd_valid, fwd_data, busy
  );

  modport slave (
    input  issue_valid, issue_rs, issue_rs_used, issue_wen, issue_rd,
           flush, wb_valid, wb_dst, wb_data,
    output issue_ready, fwd_valid, fwd_data, busy
  );
endinterface

// File: rtl/pipe_scoreboard.sv
// Register scoreboard with per-register outstanding-write counters and
// same-cycle write-back bypass.
//   clk   : core clock, rising edge
//   reset : asynchronous, active-low
//   sb    : issue request/grant, flush, write-back ports, bypass, busy
module pipe_scoreboard #(
  parameter int unsigned NREG   = 32,
  parameter int unsigned AW     = $clog2(NREG),
  parameter int unsigned NSRC   = 2,
  parameter int unsigned NWB    = 2,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned CNT_W  = 2
) (
  input logic              clk,
  input logic              reset,
  pipe_scoreboard_if.slave sb
);
  localparam int unsigned HW = $clog2(NWB + 1);
  // common compare width, one spare bit so cnt+1 never wraps
  localparam int unsigned SW = ((CNT_W > HW) ? CNT_W : HW) + 1;
  localparam logic [SW-1:0] CNT_MAX = SW'((1 << CNT_W) - 1);

  logic [CNT_W-1:0]       cnt_q [NREG];
  logic [CNT_W-1:0]       cnt_d [NREG];
  logic [NREG-1:0]        busy_q;
  logic [NREG-1:0]        busy_d;
  logic [HW-1:0]          hit [NREG];
  logic                   ready;
  logic                   fire;
  logic [NSRC-1:0]        fwd_valid;
  logic [NSRC*DATA_W-1:0] fwd_data;

  // number of write-back ports retiring each register this cycle
  always_comb begin
    for (int unsigned r = 0; r < NREG; r++) begin
      hit[r] = '0;
      for (int unsigned p = 0; p < NWB; p++) begin
        if (r != 0 && sb.wb_valid[p] && sb.wb_dst[p*AW +: AW] == AW'(r)) begin
          hit[r] = hit[r] + HW'(1);
        end
      end
    end
  end

  always_comb begin
    logic [AW-1:0] rs;
    logic [SW-1:0] c;
    logic [SW-1:0] h;
    logic [SW-1:0] rem;
    ready     = 1'b1;
    fwd_valid = '0;
    fwd_data  = '0;
    rs        = '0;
    c         = '0;
    h         = '0;
    rem       = '0;
    for (int unsigned s = 0; s < NSRC; s++) begin
      rs = sb.issue_rs[s*AW +: AW];
      c  = SW'(cnt_q[rs]);
      h  = SW'(hit[rs]);
      if (rs != '0 && c != '0) begin
        if (c == h) begin
          // all pending writes retire now: bypass, youngest port wins
          fwd_valid[s] = 1'b1;
          for (int unsigned p = 0; p < NWB; p++) begin
            if (sb.wb_valid[p] && sb.wb_dst[p*AW +: AW] == rs) begin
              fwd_data[s*DATA_W +: DATA_W] = sb.wb_data[p*DATA_W +: DATA_W];
            end
          end
        end else if (sb.issue_rs_used[s]) begin
          ready = 1'b0;
        end
      end
    end
    if (sb.issue_wen && sb.issue_rd != '0) begin
      c   = SW'(cnt_q[sb.issue_rd]);
      h   = SW'(hit[sb.issue_rd]);
      rem = (c > h) ? (c - h) : '0;
      if (rem == CNT_MAX) begin
        ready = 1'b0;
      end
    end
  end

  assign fire = sb.issue_valid && ready && !sb.flush;

  // saturating at zero absorbs stale write-backs after flush/reset
  always_comb begin
    logic [SW-1:0] sum;
    sum = '0;
    for (int unsigned r = 0; r < NREG; r++) begin
      sum = SW'(cnt_q[r]) +
            ((fire && sb.issue_wen && sb.issue_rd == AW'(r)) ? SW'(1) : SW'(0));
      if (sb.flush || r == 0) begin
        cnt_d[r] = '0;
      end else if (sum > SW'(hit[r])) begin
        cnt_d[r] = CNT_W'(sum - SW'(hit[r]));
      end else begin
        cnt_d[r] = '0;
      end
      busy_d[r] = (cnt_d[r] != '0);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q  <= '{default: '0};
      busy_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  assign sb.issue_ready = ready;
  assign sb.fwd_valid   = fwd_valid;
  assign sb.fwd_data    = fwd_data;
  assign sb.busy        = busy_q;
endmodule

// File: tb/tb_pipe_scoreboard.sv
module tb_pipe_scoreboard;
  localparam int unsigned NREG   = 32;
  localparam int unsigned AW     = 5;
  localparam int unsigned NSRC   = 2;
  localparam int unsigned NWB    = 2;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned CNT_W  = 2;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  pipe_scoreboard_if #(.NREG(NREG), .AW(AW), .NSRC(NSRC), .NWB(NWB), .DATA_W(DATA_W)) sb ();

  pipe_scoreboard #(.NREG(NREG), .AW(AW), .NSRC(NSRC), .NWB(NWB),
                    .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .sb    (sb)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    sb.issue_valid   = 1'b0;
    sb.issue_rs      = '0;
    sb.issue_rs_used = '0;
    sb.issue_wen     = 1'b0;
    sb.issue_rd      = '0;
    sb.flush         = 1'b0;
    sb.wb_valid      = '0;
    sb.wb_dst        = '0;
    sb.wb_data       = '0;
  endtask

  // advance one edge, then clear inputs just after it
  task automatic cyc();
    @(posedge clk);
    #1;
    clr();
  endtask

  task automatic iss_wr(input logic [AW-1:0] rd);
    sb.issue_valid = 1'b1;
    sb.issue_wen   = 1'b1;
    sb.issue_rd    = rd;
  endtask

  task automatic rd_src(input int s, input logic [AW-1:0] r);
    sb.issue_valid            = 1'b1;
    sb.issue_rs[s*AW +: AW]   = r;
    sb.issue_rs_used[s]       = 1'b1;
  endtask

  task automatic wb(input int p, input logic [AW-1:0] d, input logic [63:0] data);
    sb.wb_valid[p]                = 1'b1;
    sb.wb_dst[p*AW +: AW]         = d;
    sb.wb_data[p*DATA_W +: DATA_W] = data;
  endtask

  initial begin
    clr();
    reset = 1'b0;
    // reset-and-idle: activity during reset must not change state
    #3;
    wb(0, 5, 64'h1234);
    iss_wr(5);
    #1;
    chk("rst_ready", 64'(sb.issue_ready), 64'd1);
    chk("rst_fwd", 64'(sb.fwd_valid), 64'd0);
    @(posedge clk); @(posedge clk); #1;
    chk("rst_busy", 64'(sb.busy), 64'd0);
    clr();
    #3 reset = 1'b1;
    cyc();
    rd_src(0, 5);
    #1;
    chk("idle_ready", 64'(sb.issue_ready), 64'd1);
    chk("idle_fwd", 64'(sb.fwd_valid), 64'd0);
    chk("idle_busy", 64'(sb.busy), 64'd0);

    // RAW through a long-latency load
    cyc();
    iss_wr(7);
    #1 chk("raw_issue_ready", 64'(sb.issue_ready), 64'd1);
    cyc();
    chk("raw_busy7", 64'(sb.busy), 64'h80);
    for (int i = 1; i <= 3; i++) begin
      rd_src(0, 7);
      #1;
      chk("raw_stall", 64'(sb.issue_ready), 64'd0);
      chk("raw_nofwd", 64'(sb.fwd_valid), 64'd0);
      cyc();
    end
    rd_src(0, 7);
    wb(1, 7, 64'hDEAD);
    #1;
    chk("raw_wb_ready", 64'(sb.issue_ready), 64'd1);
    chk("raw_fwd_valid", 64'(sb.fwd_valid), 64'b01);
    chk("raw_fwd_data", sb.fwd_data[63:0], 64'hDEAD);
    cyc();
    chk("raw_busy_clear", 64'(sb.busy), 64'd0);
    rd_src(0, 7);
    #1;
    chk("raw_after_ready", 64'(sb.issue_ready), 64'd1);
    chk("raw_after_fwd", 64'(sb.fwd_valid), 64'd0);

    // WAW, both ports retire in one cycle: youngest port forwards
    cyc(); iss_wr(3);
    cyc(); iss_wr(3);
    cyc();
    chk("waw_busy", 64'(sb.busy), 64'h8);
    rd_src(1, 3);
    wb(0, 3, 64'h11);
    wb(1, 3, 64'h22);
    #1;
    chk("waw_ready", 64'(sb.issue_ready), 64'd1);
    chk("waw_fwd_valid", 64'(sb.fwd_valid), 64'b10);
    chk("waw_fwd_data", sb.fwd_data[127:64], 64'h22);
    cyc();
    chk("waw_busy_clear", 64'(sb.busy), 64'd0);

    // WAW, one of two retires: reader waits for the last one
    iss_wr(3);
    cyc(); iss_wr(3);
    cyc();
    rd_src(0, 3);
    wb(0, 3, 64'h33);
    #1;
    chk("waw2_stall", 64'(sb.issue_ready), 64'd0);
    chk("waw2_nofwd", 64'(sb.fwd_valid), 64'd0);
    cyc();
    chk("waw2_busy", 64'(sb.busy), 64'h8);
    rd_src(0, 3);
    wb(1, 3, 64'h44);
    #1;
    chk("waw2_ready", 64'(sb.issue_ready), 64'd1);
    chk("waw2_fwd_data", sb.fwd_data[63:0], 64'h44);
    cyc();
    chk("waw2_busy_clear", 64'(sb.busy), 64'd0);

    // counter saturation
    for (int i = 0; i < 3; i++) begin
      iss_wr(9);
      #1 chk("sat_fill", 64'(sb.issue_ready), 64'd1);
      cyc();
    end
    iss_wr(9);
    #1 chk("sat_full", 64'(sb.issue_ready), 64'd0);
    wb(0, 9, 64'h99);
    #1 chk("sat_full_wb", 64'(sb.issue_ready), 64'd1);
    cyc();
    chk("sat_busy", 64'(sb.busy), 64'h200);
    iss_wr(9);
    #1 chk("sat_still_full", 64'(sb.issue_ready), 64'd0);
    cyc();
    wb(0, 9, 64'h1);
    wb(1, 9, 64'h2);
    cyc();
    chk("sat_one_left", 64'(sb.busy), 64'h200);
    wb(0, 9, 64'h3);
    cyc();
    chk("sat_drained", 64'(sb.busy), 64'd0);

    // flush
    iss_wr(4); cyc();
    iss_wr(6); cyc();
    iss_wr(8); cyc();
    chk("fl_busy", 64'(sb.busy), 64'h150);
    sb.flush = 1'b1;
    iss_wr(10);
    wb(0, 4, 64'hF4);
    rd_src(0, 4);
    #1;
    chk("fl_fwd_valid", 64'(sb.fwd_valid), 64'b01);
    chk("fl_fwd_data", sb.fwd_data[63:0], 64'hF4);
    cyc();
    chk("fl_busy_clear", 64'(sb.busy), 64'd0);
    wb(0, 6, 64'hF6);
    cyc();
    chk("fl_stale_wb", 64'(sb.busy), 64'd0);
    iss_wr(6);
    cyc();
    chk("fl_reissue", 64'(sb.busy), 64'h40);
    wb(1, 6, 64'h6);
    cyc();

    // register 0
    for (int i = 0; i < 4; i++) begin
      iss_wr(0);
      rd_src(0, 0);
      rd_src(1, 0);
      wb(0, 0, 64'h55);
      #1;
      chk("r0_ready", 64'(sb.issue_ready), 64'd1);
      chk("r0_fwd", 64'(sb.fwd_valid), 64'd0);
      cyc();
      chk("r0_busy", 64'(sb.busy), 64'd0);
    end

    // simultaneous issue and write-back to the same register: net zero
    iss_wr(12); cyc();
    iss_wr(12);
    wb(0, 12, 64'hC);
    #1 chk("same_ready", 64'(sb.issue_ready), 64'd1);
    cyc();
    chk("same_busy", 64'(sb.busy), 64'h1000);
    wb(1, 12, 64'hC);
    cyc();
    chk("same_clear", 64'(sb.busy), 64'd0);

    // asynchronous reset mid-operation, then stale write-back
    iss_wr(13);
    cyc();
    chk("arst_pre", 64'(sb.busy), 64'h2000);
    #2 reset = 1'b0;
    #1;
    chk("arst_busy", 64'(sb.busy), 64'd0);
    rd_src(0, 13);
    #1 chk("arst_ready", 64'(sb.issue_ready), 64'd1);
    cyc();
    #3 reset = 1'b1;
    cyc();
    wb(0, 13, 64'hD);
    cyc();
    chk("arst_stale", 64'(sb.busy), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
